// File: rtl/icache_refill.sv
// icache_refill: miss-service engine for the two-way instruction cache.
// It accepts a fetch miss and issues one AXI4 read burst for the missing line.
// The returned beats are gathered in a line buffer, and the finished line,
// its tag and its way are written to the cache arrays with a one-cycle strobe.
//
// Optional feature macro: ICACHE_REFILL_CWF_EN (critical-word-first, WRAP burst).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_miss_i, if_addr_i        level miss request and miss PC from fetch
//   lru_way_i                   LRU bit of the missing set, sampled in FILL
//   flush_i                     cancels an outstanding refill (AR/R only)
//   ar_*                        AXI read-address channel
//   r_*                         AXI read-data channel
//   fill_valid_o, fill_set_o, fill_way_o, fill_tag_o, fill_data_o
//                               one-cycle write port into the cache arrays
//   busy_o                      engine not idle
//   fault_o                     one-cycle pulse on bus or burst-length error
module icache_refill #(
  parameter  int unsigned B          = 8,
  localparam int unsigned OFF_W      = $clog2(B),
  localparam int unsigned BYTE_W     = 3,
  localparam int unsigned SET_W      = 6,
  localparam int unsigned TAG_W      = 64 - SET_W - OFF_W - BYTE_W,
  localparam int unsigned LINE_OFF_W = OFF_W + BYTE_W,
  localparam int unsigned LINE_W     = 64 * B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_miss_i,
  input  logic [63:0]       if_addr_i,
  input  logic              lru_way_i,
  input  logic              flush_i,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [63:0]       ar_addr_o,
  output logic [7:0]        ar_len_o,
  output logic [2:0]        ar_size_o,
  output logic [1:0]        ar_burst_o,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [63:0]       r_data_i,
  input  logic [1:0]        r_resp_i,
  input  logic              r_last_i,
  output logic              fill_valid_o,
  output logic [SET_W-1:0]  fill_set_o,
  output logic              fill_way_o,
  output logic [TAG_W-1:0]  fill_tag_o,
  output logic [LINE_W-1:0] fill_data_o,
  output logic              busy_o,
  output logic              fault_o
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_FILL, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic [63:0]            ar_addr_q, ar_addr_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   cancel_q, cancel_d;
  logic [B-1:0][63:0]     line_q, line_d;
  logic [SET_W-1:0]       fill_set_q, fill_set_d;
  logic [TAG_W-1:0]       fill_tag_q, fill_tag_d;
  logic                   fill_way_q, fill_way_d;
  logic                   fill_valid_q, fill_valid_d;
  logic                   fault_q, fault_d;
  logic                   ar_valid_q, r_ready_q, busy_q;
  logic                   beat;
  logic [OFF_W-1:0]       start_word;
  logic [OFF_W-1:0]       wr_idx;
  logic [63:0]            ar_addr_new;

  // Byte offset (and word offset without CWF) never reaches the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^if_addr_i[LINE_OFF_W-1:0];

`ifdef ICACHE_REFILL_CWF_EN
  assign ar_addr_new = {if_addr_i[63:BYTE_W], BYTE_W'(0)};
  assign ar_burst_o  = 2'b10;
`else
  assign ar_addr_new = {if_addr_i[63:LINE_OFF_W], LINE_OFF_W'(0)};
  assign ar_burst_o  = 2'b01;
`endif

  // The word offset held in ar_addr is the first beat's slot (zero when line-aligned).
  assign start_word = ar_addr_q[BYTE_W +: OFF_W];
  assign wr_idx     = OFF_W'(start_word + cnt_q);
  assign beat       = r_ready_q && r_valid_i;

  assign ar_len_o   = 8'(B - 1);
  assign ar_size_o  = 3'b011;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    ar_addr_d    = ar_addr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    cancel_d     = cancel_q;
    line_d       = line_q;
    fill_set_d   = fill_set_q;
    fill_tag_d   = fill_tag_q;
    fill_way_d   = fill_way_q;
    fill_valid_d = 1'b0;
    fault_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (if_miss_i) begin
          ar_addr_d = ar_addr_new;
          err_d     = 1'b0;
          cancel_d  = 1'b0;
          state_d   = S_AR;
        end
      end
      S_AR: begin
        cnt_d = '0;
        if (flush_i)    cancel_d = 1'b1;
        if (ar_ready_i) state_d  = S_R;
      end
      S_R: begin
        if (flush_i) cancel_d = 1'b1;
        if (beat) begin
          line_d[wr_idx] = r_data_i;
          cnt_d          = cnt_q + OFF_W'(1);
          if (r_resp_i != 2'b00) err_d = 1'b1;
          if (r_last_i) begin
            // Errors win over cancel so a cancelled faulty burst still reports.
            if (err_d || (cnt_q != OFF_W'(B - 1))) begin
              fault_d = 1'b1;
              state_d = S_HOLD;
            end else if (cancel_d) begin
              state_d = S_HOLD;
            end else begin
              state_d = S_FILL;
            end
          end
        end
      end
      S_FILL: begin
        fill_valid_d = 1'b1;
        fill_set_d   = ar_addr_q[LINE_OFF_W +: SET_W];
        fill_tag_d   = ar_addr_q[63 -: TAG_W];
        fill_way_d   = lru_way_i;
        state_d      = S_HOLD;
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_addr_q    <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      cancel_q     <= 1'b0;
      line_q       <= '0;
      fill_set_q   <= '0;
      fill_tag_q   <= '0;
      fill_way_q   <= 1'b0;
      fill_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ar_addr_q    <= ar_addr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      cancel_q     <= cancel_d;
      line_q       <= line_d;
      fill_set_q   <= fill_set_d;
      fill_tag_q   <= fill_tag_d;
      fill_way_q   <= fill_way_d;
      fill_valid_q <= fill_valid_d;
      fault_q      <= fault_d;
      ar_valid_q   <= (state_d == S_AR);
      r_ready_q    <= (state_d == S_R);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign ar_valid_o   = ar_valid_q;
  assign ar_addr_o    = ar_addr_q;
  assign r_ready_o    = r_ready_q;
  assign fill_valid_o = fill_valid_q;
  assign fill_set_o   = fill_set_q;
  assign fill_way_o   = fill_way_q;
  assign fill_tag_o   = fill_tag_q;
  assign fill_data_o  = line_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed and randomized refills against a line-level
// model of the miss engine and an AXI slave returning a known memory pattern.
module tb_icache_refill;

  localparam int unsigned B      = 8;
  localparam int unsigned LINE_W = 64 * B;

  logic              clk;
  logic              rst_n;
  logic              if_miss;
  logic [63:0]       if_addr;
  logic              lru_way;
  logic              flush;
  logic              ar_valid;
  logic              ar_ready;
  logic [63:0]       ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              r_valid;
  logic              r_ready;
  logic [63:0]       r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              fill_valid;
  logic [5:0]        fill_set;
  logic              fill_way;
  logic [51:0]       fill_tag;
  logic [LINE_W-1:0] fill_data;
  logic              busy;
  logic              fault;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [31:0] salt;

  icache_refill #(.B(B)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_miss_i    (if_miss),
    .if_addr_i    (if_addr),
    .lru_way_i    (lru_way),
    .flush_i      (flush),
    .ar_valid_o   (ar_valid),
    .ar_ready_i   (ar_ready),
    .ar_addr_o    (ar_addr),
    .ar_len_o     (ar_len),
    .ar_size_o    (ar_size),
    .ar_burst_o   (ar_burst),
    .r_valid_i    (r_valid),
    .r_ready_o    (r_ready),
    .r_data_i     (r_data),
    .r_resp_i     (r_resp),
    .r_last_i     (r_last),
    .fill_valid_o (fill_valid),
    .fill_set_o   (fill_set),
    .fill_way_o   (fill_way),
    .fill_tag_o   (fill_tag),
    .fill_data_o  (fill_data),
    .busy_o       (busy),
    .fault_o      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs,
                          input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents of word w of the line currently being fetched.
  function automatic logic [63:0] mem_word(input logic [31:0] s, input int w);
    return {s ^ 32'hC0DE_0000, s + 32'(w) * 32'h0001_0003};
  endfunction

  // One complete miss: IDLE -> burst -> fill or abort -> back to IDLE.
  // flush_beat: -1 none, -2 during AR, else beat index.
  task automatic refill(input logic [63:0] addr, input logic lru, input int ar_dly,
                        input int err_beat, input int last_beat, input int flush_beat,
                        input bit gaps, input bit keep_miss, input bit late_flush);
    logic [63:0]       exp_ar;
    logic [1:0]        exp_burst;
    logic [LINE_W-1:0] exp_line;
    int                start;
    int                t0;
    bit                exp_fault;
    bit                exp_fill;
    salt = $urandom;
`ifdef ICACHE_REFILL_CWF_EN
    exp_ar    = {addr[63:3], 3'b000};
    exp_burst = 2'b10;
    start     = int'(addr[5:3]);
`else
    exp_ar    = {addr[63:6], 6'b000000};
    exp_burst = 2'b01;
    start     = 0;
`endif
    for (int w = 0; w < B; w++) exp_line[64*w +: 64] = mem_word(salt, w);
    exp_fault = ((err_beat >= 0) && (err_beat <= last_beat)) || (last_beat != B - 1);
    exp_fill  = !exp_fault && (flush_beat == -1);

    if_miss = 1'b1;
    if_addr = addr;
    lru_way = lru;
    flush   = late_flush;
    t0      = cyc;
    step();
    flush = (flush_beat == -2);
    chk("ar_valid_rise", 64'(ar_valid), 64'(1));
    chk("busy_ar", 64'(busy), 64'(1));
    chk("ar_addr", ar_addr, exp_ar);
    chk("ar_burst", 64'(ar_burst), 64'(exp_burst));
    for (int k = 0; k < ar_dly; k++) begin
      if_addr  = {$urandom, $urandom};
      ar_ready = 1'b0;
      step();
      flush = 1'b0;
      chk("ar_valid_hold", 64'(ar_valid), 64'(1));
      chk("ar_addr_stable", ar_addr, exp_ar);
    end
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    flush    = 1'b0;
    chk("ar_valid_drop", 64'(ar_valid), 64'(0));
    chk("r_ready_rise", 64'(r_ready), 64'(1));

    for (int i = 0; i <= last_beat; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          r_valid = 1'b0;
          step();
        end
      end
      r_valid = 1'b1;
      r_data  = mem_word(salt, (start + i) % B);
      r_resp  = (i == err_beat) ? 2'b10 : 2'b00;
      r_last  = (i == last_beat);
      flush   = (i == flush_beat);
      step();
      r_valid = 1'b0;
      r_last  = 1'b0;
      r_resp  = 2'b00;
      flush   = 1'b0;
      if (i != last_beat) chk("r_ready_mid", 64'(r_ready), 64'(1));
    end

    chk("fault_after_last", 64'(fault), 64'(exp_fault));
    chk("no_fill_after_last", 64'(fill_valid), 64'(0));
    chk("r_ready_drop", 64'(r_ready), 64'(0));
    chk("busy_after_last", 64'(busy), 64'(1));

    if (exp_fill) begin
      flush = late_flush;
      step();
      flush = 1'b0;
      chk("fill_valid", 64'(fill_valid), 64'(1));
      chk("fill_set", 64'(fill_set), 64'(addr[11:6]));
      chk("fill_tag", 64'(fill_tag), 64'(addr[63:12]));
      chk("fill_way", 64'(fill_way), 64'(lru));
      chk_line("fill_data", fill_data, exp_line);
      chk("fault_with_fill", 64'(fault), 64'(0));
      if ((ar_dly == 0) && !gaps) chk("fill_latency", 64'(cyc - t0), 64'(3 + B));
      if_miss = keep_miss;
      step();
      chk("fill_one_cycle", 64'(fill_valid), 64'(0));
    end else begin
      if_miss = keep_miss;
      step();
      chk("fault_one_cycle", 64'(fault), 64'(0));
      chk("no_fill_abort", 64'(fill_valid), 64'(0));
    end
    chk("busy_idle", 64'(busy), 64'(0));
    chk("no_reissue_from_hold", 64'(ar_valid), 64'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    if_miss  = 1'b0;
    if_addr  = '0;
    lru_way  = 1'b0;
    flush    = 1'b0;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    r_data   = '0;
    r_resp   = 2'b00;
    r_last   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ar_valid", 64'(ar_valid), 64'(0));
    chk("rst_r_ready", 64'(r_ready), 64'(0));
    chk("rst_fill_valid", 64'(fill_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_fault", 64'(fault), 64'(0));
    chk("rst_ar_addr", ar_addr, 64'(0));
    chk("rst_fill_set", 64'(fill_set), 64'(0));
    chk("rst_fill_tag", 64'(fill_tag), 64'(0));
    chk_line("rst_fill_data", fill_data, '0);
    chk("ar_len", 64'(ar_len), 64'(B - 1));
    chk("ar_size", 64'(ar_size), 64'(3));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Flush while idle has no effect.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("idle_flush_busy", 64'(busy), 64'(0));

    refill(64'h0000_0000_8000_1048, 1'b1, 0, -1, 7, -1, 1'b0, 1'b0, 1'b0);
    refill(64'h0000_0000_8000_1048, 1'b0, 0, 3, 7, -1, 1'b0, 1'b1, 1'b0);
    refill(64'h0000_0000_8000_1048, 1'b0, 0, -1, 7, -1, 1'b0, 1'b0, 1'b0);
    refill(64'h0000_0040_1234_5678, 1'b1, 0, -1, 7, 2, 1'b0, 1'b0, 1'b0);
    refill(64'h1234_5678_9ABC_DEF0, 1'b0, 0, -1, 4, -1, 1'b0, 1'b0, 1'b0);
    refill(64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 4, -1, 7, -1, 1'b0, 1'b0, 1'b1);
    refill(64'h0000_0000_0000_0000, 1'b0, 2, -1, 7, -2, 1'b0, 1'b0, 1'b0);
    refill(64'hA5A5_0000_0000_03F8, 1'b1, 0, -1, 7, 7, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of the data phase.
    if_miss = 1'b1;
    if_addr = 64'h0000_0000_0000_2000;
    step();
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_valid = 1'b1;
      r_data  = 64'(i);
      step();
    end
    r_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midr_rst_busy", 64'(busy), 64'(0));
    chk("midr_rst_r_ready", 64'(r_ready), 64'(0));
    chk("midr_rst_fault", 64'(fault), 64'(0));
    if_miss = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 64'(busy), 64'(0));

    for (int n = 0; n < 16; n++) begin
      int mode;
      int eb;
      int lb;
      int fb;
      mode = int'($urandom_range(0, 9));
      eb   = -1;
      lb   = B - 1;
      fb   = -1;
      if (mode == 0) eb = int'($urandom_range(0, B - 1));
      if (mode == 1) lb = int'($urandom_range(0, B - 2));
      if (mode == 2) fb = int'($urandom_range(0, B - 1));
      if (mode == 3) fb = -2;
      refill({$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             eb, lb, fb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-service engine for the two-way instruction cache. Consumes the fetch stage's miss indication and miss address, issues one AXI4 read burst for the missing line, assembles the returned beats in a line buffer, and writes the completed line, tag and way back into the cache arrays in one cycle. It sits between the IF stage lookup and the AXI read channel of the memory interconnect.

## Interface
- `B`, 8: 64-bit words per line (power of two, 2..16).
- `s`, 6: set-index bits.
- `b`, 3: block-offset bits (log2 B).
- `y`, 3: byte-offset bits (fixed 3, 64-bit word).
- `t`, 52: tag bits (64 - s - b - y).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `IF_miss`  in  1  level miss request from fetch; held until fill.
- `IF_addr`  in  64  miss PC; sampled only on acceptance.
- `lru_way`  in  1  LRU bit of the missing set, from cache; sampled at FILL.
- `flush`  in  1  one-cycle pulse; cancels the outstanding refill.
- `ar_valid`/`ar_ready`  out/in  1  AXI read-address handshake.
- `ar_addr`  out  64  burst start address.
- `ar_len`  out  8  B-1.
- `ar_size`  out  3  constant 3'b011.
- `ar_burst`  out  2  INCR (2'b01) or WRAP (2'b10), per Configuration.
- `r_valid`/`r_ready`  in/out  1  AXI read-data handshake.
- `r_data`  in  64  beat data.
- `r_resp`  in  2  beat response; nonzero = error.
- `r_last`  in  1  final beat.
- `fill_valid`  out  1  one-cycle write strobe to cache arrays.
- `fill_set`  out  s  target set.
- `fill_way`  out  1  target way (= `lru_way`).
- `fill_tag`  out  t  tag written with valid=1.
- `fill_data`  out  64*B  line; word i at bits [64i+63:64i].
- `busy`  out  1  high in any state other than IDLE.
- `fault`  out  1  one-cycle pulse on bus error or burst-length error.

## Operation
- States: IDLE, AR, R, FILL, HOLD.
- IDLE: `IF_miss`=1 latches `IF_addr` into `miss_addr` and moves to AR.
- AR: `ar_valid`=1, `ar_addr`/`ar_len`/`ar_burst` stable until `ar_ready`; handshake moves to R. Beat counter cleared.
- R: `r_ready`=1. Each accepted beat writes `r_data` to buffer word `(start_word + cnt) mod B` and increments `cnt` (b bits, wraps). A nonzero `r_resp` sets a sticky `err`. On `r_last`: if `err`, or `cnt`≠B-1, or `cancel` set, go to HOLD with `fault`=1 for the error cases (not for cancel-only); otherwise go to FILL.
- FILL: `fill_valid`=1 for exactly one cycle; set/tag from `miss_addr`, way from `lru_way`. Then HOLD.
- HOLD: one idle cycle so the cache can deassert `IF_miss` from the new tag; `IF_miss` is ignored here. Then IDLE.
- `flush` in AR or R sets `cancel`. The burst is not aborted (AXI has no abort), so AR completes its handshake and R drains every beat. No fill occurs; the next miss starts after HOLD. `flush` in IDLE/FILL/HOLD has no effect.
- `fault` does not write the cache. Fetch retries by holding `IF_miss`, which re-issues the burst.
- Without `r_last`, R never exits. There is no beat timeout.

## Timing
- Reset values: state IDLE; `ar_valid`, `r_ready`, `fill_valid`, `busy`, `fault`, `err`, `cancel` = 0; `ar_addr`, `fill_*`, buffer, `cnt` = 0.
- `ar_valid` rises the cycle after `IF_miss` is sampled high in IDLE.
- Minimum miss-to-`fill_valid` latency = 3 + B cycles with zero-wait `ar_ready` and `r_valid`.
- `fill_valid` and `fault` are never asserted in the same cycle.
- `rst_n` low mid-burst returns to IDLE immediately and drops `r_ready`. The interconnect is reset on the same net, so no stray beats arrive.

## Configuration
- `ICACHE_REFILL_CWF_EN` defined: critical-word-first. `ar_addr = {miss_addr[63:3],3'b0}`, `ar_burst`=WRAP, `start_word = miss_addr[b+y-1:y]`.
- `ICACHE_REFILL_CWF_EN` undefined: `ar_addr` is line-aligned (low b+y bits zero), `ar_burst`=INCR, `start_word`=0.
- Buffer placement makes `fill_data` identical in both builds.

## Test plan
- B=8, miss at 0x8000_1048, zero-wait slave → `ar_addr`=0x8000_1040 INCR len 7; `fill_valid` at cycle 11 with set/tag from 0x1048; `fill_data` word i = pattern i.
- Same miss with `ICACHE_REFILL_CWF_EN` → `ar_addr`=0x8000_1048 WRAP; beats 1,2..7,0 land so `fill_data` equals the previous case.
- `r_resp`=2'b10 on beat 3 → no `fill_valid`; `fault` pulses one cycle after `r_last`; held `IF_miss` re-issues AR after HOLD.
- `flush` during beat 2 → all 8 beats accepted, no `fill_valid`, no `fault`, `busy` low two cycles after `r_last`.
- `r_last` on beat 5 of 8 → `fault`=1, no fill; `rst_n` pulsed mid-R → `busy`=0 and `r_ready`=0 immediately.
- `ar_ready` delayed 4 cycles with `IF_addr` changing → `ar_addr` stays stable and reflects the originally latched address.
